// File: rtl/reg_cr_file_pkg.sv
// Shared CR record layout, field-enable bit positions and the per-field write-merge used by
// both the register update and the read forwarding path. CR_MONOTONIC_EN gates tag clearing.
package reg_cr_file_pkg;

    localparam int NUM_CR = 4;
    localparam int AW     = (NUM_CR > 1) ? $clog2(NUM_CR) : 1;
    localparam int ADDR_W = 48;
    localparam int DATA_W = 24;
    localparam int CR_W   = 3*ADDR_W + 2*DATA_W + 1;

    localparam int OFF_BASE  = 0;
    localparam int OFF_LEN   = OFF_BASE  + ADDR_W;
    localparam int OFF_CUR   = OFF_LEN   + ADDR_W;
    localparam int OFF_PERMS = OFF_CUR   + ADDR_W;
    localparam int OFF_ATTR  = OFF_PERMS + DATA_W;
    localparam int OFF_TAG   = OFF_ATTR  + DATA_W;

    localparam int FE_BASE  = 0;
    localparam int FE_LEN   = 1;
    localparam int FE_CUR   = 2;
    localparam int FE_PERMS = 3;
    localparam int FE_ATTR  = 4;
    localparam int FE_TAG   = 5;
    localparam int FE_W     = 6;

    typedef struct packed {
        logic              tag;
        logic [DATA_W-1:0] attr;
        logic [DATA_W-1:0] perms;
        logic [ADDR_W-1:0] cur;
        logic [ADDR_W-1:0] len;
        logic [ADDR_W-1:0] base;
    } cr_t;

    typedef struct packed {
        logic [AW-1:0]     cr_addr;
        logic [FE_W-1:0]   cr_we;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] len;
        logic [ADDR_W-1:0] cur;
        logic [DATA_W-1:0] perms;
        logic [DATA_W-1:0] attr;
        logic              tag;
        logic              ar_we;
        logic [AW-1:0]     ar_addr;
        logic [ADDR_W-1:0] ar_data;
    } cr_wr_t;

    function automatic logic idx_valid(input logic [AW-1:0] idx);
        return (NUM_CR == (1 << AW)) || (32'(idx) < NUM_CR);
    endfunction

    // Contents of CR[idx] after this cycle's write set; the CR-path cur beats the AR path.
    function automatic cr_t cr_merge(input cr_t old, input logic [AW-1:0] idx, input cr_wr_t wr);
        cr_t  nxt;
        logic cr_hit;
        logic ar_hit;
        nxt    = old;
        cr_hit = idx_valid(wr.cr_addr) && (wr.cr_addr == idx);
        ar_hit = wr.ar_we && idx_valid(wr.ar_addr) && (wr.ar_addr == idx);
        if (cr_hit && wr.cr_we[FE_BASE])  nxt.base  = wr.base;
        if (cr_hit && wr.cr_we[FE_LEN])   nxt.len   = wr.len;
        if (cr_hit && wr.cr_we[FE_PERMS]) nxt.perms = wr.perms;
        if (cr_hit && wr.cr_we[FE_ATTR])  nxt.attr  = wr.attr;
        if (cr_hit && wr.cr_we[FE_TAG])   nxt.tag   = wr.tag;
        if (cr_hit && wr.cr_we[FE_CUR])   nxt.cur   = wr.cur;
        else if (ar_hit)                  nxt.cur   = wr.ar_data;
`ifdef CR_MONOTONIC_EN
        if (cr_hit && (|wr.cr_we) && !wr.cr_we[FE_TAG]) begin
            if ((nxt.base < old.base) ||
                (({1'b0, nxt.base} + {1'b0, nxt.len}) > ({1'b0, old.base} + {1'b0, old.len})))
                nxt.tag = 1'b0;
        end
`endif
        return nxt;
    endfunction

endpackage

// File: rtl/reg_cr_file_fwd.sv
// Read-port forwarding mux: merges this cycle's writes into the addressed CR, zero if out of range.
// Purely combinational; the top registers the result.
module reg_cr_fwd
    import reg_cr_file_pkg::*;
(
    input  logic [AW-1:0] iw_raddr,
    input  cr_t           iw_old,
    input  cr_wr_t        iw_wr,
    output cr_t           ow_rd
);

    always_comb begin
        ow_rd = '0;
        if (idx_valid(iw_raddr))
            ow_rd = cr_merge(iw_old, iw_raddr, iw_wr);
    end

endmodule

// File: rtl/reg_cr_file.sv
// Capability-register file: per-field CR writes plus AR cur writes, two registered read ports
// with same-cycle write forwarding (1-cycle latency, no stall). CR_MONOTONIC_EN enables tag clearing.
module reg_cr_file
    import reg_cr_file_pkg::*;
(
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic [AW-1:0]     iw_cr_write_addr,
    input  logic              iw_cr_we_base,
    input  logic [ADDR_W-1:0] iw_cr_base,
    input  logic              iw_cr_we_len,
    input  logic [ADDR_W-1:0] iw_cr_len,
    input  logic              iw_cr_we_cur,
    input  logic [ADDR_W-1:0] iw_cr_cur,
    input  logic              iw_cr_we_perms,
    input  logic [DATA_W-1:0] iw_cr_perms,
    input  logic              iw_cr_we_attr,
    input  logic [DATA_W-1:0] iw_cr_attr,
    input  logic              iw_cr_we_tag,
    input  logic              iw_cr_tag,
    input  logic              iw_ar_write_enable,
    input  logic [AW-1:0]     iw_ar_write_addr,
    input  logic [ADDR_W-1:0] iw_ar_write_data,
    input  logic [AW-1:0]     iw_cr_raddr_a,
    input  logic [AW-1:0]     iw_cr_raddr_b,
    output logic [CR_W-1:0]   ow_cr_a,
    output logic [CR_W-1:0]   ow_cr_b,
    output logic              ow_wr_conflict
);

    cr_wr_t wr;
    cr_t    regs_q [NUM_CR];
    cr_t    regs_d [NUM_CR];
    cr_t    old_a;
    cr_t    old_b;
    cr_t    rd_a_d;
    cr_t    rd_a_q;
    cr_t    rd_b_d;
    cr_t    rd_b_q;
    logic   conflict_d;
    logic   conflict_q;

    always_comb begin
        wr                 = '0;
        wr.cr_addr         = iw_cr_write_addr;
        wr.cr_we[FE_BASE]  = iw_cr_we_base;
        wr.cr_we[FE_LEN]   = iw_cr_we_len;
        wr.cr_we[FE_CUR]   = iw_cr_we_cur;
        wr.cr_we[FE_PERMS] = iw_cr_we_perms;
        wr.cr_we[FE_ATTR]  = iw_cr_we_attr;
        wr.cr_we[FE_TAG]   = iw_cr_we_tag;
        wr.base            = iw_cr_base;
        wr.len             = iw_cr_len;
        wr.cur             = iw_cr_cur;
        wr.perms           = iw_cr_perms;
        wr.attr            = iw_cr_attr;
        wr.tag             = iw_cr_tag;
        wr.ar_we           = iw_ar_write_enable;
        wr.ar_addr         = iw_ar_write_addr;
        wr.ar_data         = iw_ar_write_data;
    end

    always_comb begin
        for (int i = 0; i < NUM_CR; i++)
            regs_d[i] = cr_merge(regs_q[i], AW'(i), wr);
    end

    always_comb begin
        conflict_d = iw_ar_write_enable && iw_cr_we_cur &&
                     (iw_ar_write_addr == iw_cr_write_addr) && idx_valid(iw_cr_write_addr);
    end

    // Out-of-range addresses select garbage here; the fwd mux zeroes them.
    assign old_a = regs_q[iw_cr_raddr_a];
    assign old_b = regs_q[iw_cr_raddr_b];

    reg_cr_fwd u_fwd_a (
        .iw_raddr (iw_cr_raddr_a),
        .iw_old   (old_a),
        .iw_wr    (wr),
        .ow_rd    (rd_a_d)
    );

    reg_cr_fwd u_fwd_b (
        .iw_raddr (iw_cr_raddr_b),
        .iw_old   (old_b),
        .iw_wr    (wr),
        .ow_rd    (rd_b_d)
    );

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            for (int i = 0; i < NUM_CR; i++)
                regs_q[i] <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CR; i++)
                regs_q[i] <= regs_d[i];
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            conflict_q <= conflict_d;
        end
    end

    assign ow_cr_a        = rd_a_q;
    assign ow_cr_b        = rd_b_q;
    assign ow_wr_conflict = conflict_q;

endmodule

// File: tb/tb_reg_cr_file.sv
// Self-checking bench for reg_cr_file: directed vector table then random write sets,
// expectations from a behavioural register model queued at drive time and popped after the edge.
module tb_reg_cr_file;
    import reg_cr_file_pkg::*;

    typedef struct {
        string             name;
        logic              rst_n;
        logic [AW-1:0]     cr_addr;
        logic [FE_W-1:0]   we;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] len;
        logic [ADDR_W-1:0] cur;
        logic [DATA_W-1:0] perms;
        logic [DATA_W-1:0] attr;
        logic              tag;
        logic              ar_we;
        logic [AW-1:0]     ar_addr;
        logic [ADDR_W-1:0] ar_data;
        logic [AW-1:0]     ra;
        logic [AW-1:0]     rb;
        logic              exp_conf;
    } vec_t;

    typedef struct {
        string name;
        cr_t   a;
        cr_t   b;
        logic  conf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     cr_addr;
    logic              we_base, we_len, we_cur, we_perms, we_attr, we_tag;
    logic [ADDR_W-1:0] base, len, cur;
    logic [DATA_W-1:0] perms, attr;
    logic              tag;
    logic              ar_we;
    logic [AW-1:0]     ar_addr;
    logic [ADDR_W-1:0] ar_data;
    logic [AW-1:0]     ra, rb;
    logic [CR_W-1:0]   cr_a, cr_b;
    logic              conflict;

    cr_t  m [NUM_CR];
    exp_t sb_q [$];
    vec_t tbl [$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    reg_cr_file dut (
        .iw_clk             (clk),
        .iw_rst_n           (rst_n),
        .iw_cr_write_addr   (cr_addr),
        .iw_cr_we_base      (we_base),
        .iw_cr_base         (base),
        .iw_cr_we_len       (we_len),
        .iw_cr_len          (len),
        .iw_cr_we_cur       (we_cur),
        .iw_cr_cur          (cur),
        .iw_cr_we_perms     (we_perms),
        .iw_cr_perms        (perms),
        .iw_cr_we_attr      (we_attr),
        .iw_cr_attr         (attr),
        .iw_cr_we_tag       (we_tag),
        .iw_cr_tag          (tag),
        .iw_ar_write_enable (ar_we),
        .iw_ar_write_addr   (ar_addr),
        .iw_ar_write_data   (ar_data),
        .iw_cr_raddr_a      (ra),
        .iw_cr_raddr_b      (rb),
        .ow_cr_a            (cr_a),
        .ow_cr_b            (cr_b),
        .ow_wr_conflict     (conflict)
    );

    function automatic vec_t mk(input string nm, input logic r, input int cra, input logic [5:0] w,
                                input longint b, input longint l, input longint c,
                                input int p, input int at, input logic t,
                                input logic arw, input int ara, input longint ard,
                                input int a_idx, input int b_idx, input logic cf);
        vec_t v;
        v.name = nm;  v.rst_n = r;  v.cr_addr = AW'(cra);  v.we = w;
        v.base = ADDR_W'(b);  v.len = ADDR_W'(l);  v.cur = ADDR_W'(c);
        v.perms = DATA_W'(p);  v.attr = DATA_W'(at);  v.tag = t;
        v.ar_we = arw;  v.ar_addr = AW'(ara);  v.ar_data = ADDR_W'(ard);
        v.ra = AW'(a_idx);  v.rb = AW'(b_idx);  v.exp_conf = cf;
        return v;
    endfunction

    // Behavioural reference: AR write applied first, then CR fields overwrite.
    task automatic model_step(input vec_t v, output exp_t e);
        cr_t old;
        e.name = v.name;  e.a = '0;  e.b = '0;  e.conf = 1'b0;
        if (!v.rst_n) begin
            for (int i = 0; i < NUM_CR; i++) m[i] = '0;
            return;
        end
        old = m[v.cr_addr];
        if (v.ar_we) m[v.ar_addr].cur = v.ar_data;
        if (v.we[FE_BASE])  m[v.cr_addr].base  = v.base;
        if (v.we[FE_LEN])   m[v.cr_addr].len   = v.len;
        if (v.we[FE_CUR])   m[v.cr_addr].cur   = v.cur;
        if (v.we[FE_PERMS]) m[v.cr_addr].perms = v.perms;
        if (v.we[FE_ATTR])  m[v.cr_addr].attr  = v.attr;
        if (v.we[FE_TAG])   m[v.cr_addr].tag   = v.tag;
`ifdef CR_MONOTONIC_EN
        if (v.we != '0 && !v.we[FE_TAG]) begin
            if (m[v.cr_addr].base < old.base ||
                ({1'b0, m[v.cr_addr].base} + {1'b0, m[v.cr_addr].len}) >
                ({1'b0, old.base} + {1'b0, old.len}))
                m[v.cr_addr].tag = 1'b0;
        end
`endif
        e.a = m[v.ra];
        e.b = m[v.rb];
        e.conf = v.ar_we && v.we[FE_CUR] && (v.ar_addr == v.cr_addr);
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst_n;  cr_addr = v.cr_addr;
        {we_tag, we_attr, we_perms, we_cur, we_len, we_base} = v.we;
        base = v.base;  len = v.len;  cur = v.cur;  perms = v.perms;  attr = v.attr;  tag = v.tag;
        ar_we = v.ar_we;  ar_addr = v.ar_addr;  ar_data = v.ar_data;  ra = v.ra;  rb = v.rb;
    endtask

    task automatic chk_cr(input string nm, input logic [CR_W-1:0] got, input cr_t exp);
        logic [CR_W-1:0] ev;
        ev = exp;
        n_total++;
        if (got === ev) n_pass++;
        else $display("FAIL %s: got tag=%0b attr=%h perms=%h cur=%h len=%h base=%h, required tag=%0b attr=%h perms=%h cur=%h len=%h base=%h",
                      nm, got[OFF_TAG], got[OFF_ATTR +: DATA_W], got[OFF_PERMS +: DATA_W],
                      got[OFF_CUR +: ADDR_W], got[OFF_LEN +: ADDR_W], got[OFF_BASE +: ADDR_W],
                      exp.tag, exp.attr, exp.perms, exp.cur, exp.len, exp.base);
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard: output cycle with no queued expectation");
            return;
        end
        e = sb_q.pop_front();
        chk_cr({e.name, ".a"}, cr_a, e.a);
        chk_cr({e.name, ".b"}, cr_b, e.b);
        n_total++;
        if (conflict === e.conf) n_pass++;
        else $display("FAIL %s.conflict: got %0b required %0b", e.name, conflict, e.conf);
    endtask

    task automatic run_vec(input vec_t v, input logic use_tbl_conf);
        exp_t e;
        @(negedge clk);
        drive(v);
        model_step(v, e);
        if (use_tbl_conf) e.conf = v.exp_conf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        drive(mk("init", 1'b0, 0, 6'h00, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0));

        //            name        rst  cra we      base     len     cur     perms     attr  tag  arw  ara ard     ra rb conf
        tbl.push_back(mk("rst_wr",  1'b0, 2, 6'h3f, 'h777,   'h77,   'h7,    'h7,      'h7,  1'b1, 1'b1, 2, 'h9,   2, 3, 1'b0));
        tbl.push_back(mk("rd01",    1'b1, 0, 6'h00, 0,       0,      0,      0,        0,    1'b0, 1'b0, 0, 0,     0, 1, 1'b0));
        tbl.push_back(mk("rd23",    1'b1, 0, 6'h00, 0,       0,      0,      0,        0,    1'b0, 1'b0, 0, 0,     2, 3, 1'b0));
        tbl.push_back(mk("wr2_fwd", 1'b1, 2, 6'h23, 'h1000,  'h100,  0,      0,        0,    1'b1, 1'b0, 0, 0,     2, 0, 1'b0));
        tbl.push_back(mk("collide", 1'b1, 1, 6'h04, 0,       0,      'h2000, 0,        0,    1'b0, 1'b1, 1, 'h1040, 1, 1, 1'b1));
        tbl.push_back(mk("ar3_cr1", 1'b1, 1, 6'h04, 0,       0,      'h2222, 0,        0,    1'b0, 1'b1, 3, 'h3333, 3, 1, 1'b0));
        tbl.push_back(mk("ar_only", 1'b1, 0, 6'h00, 0,       0,      0,      0,        0,    1'b0, 1'b1, 2, 'h1080, 2, 2, 1'b0));
        tbl.push_back(mk("wr0_all", 1'b1, 0, 6'h3f, 'h11,    'h22,   'h33,   'h44,     'h55, 1'b1, 1'b0, 0, 0,     0, 2, 1'b0));
        tbl.push_back(mk("wr0_prm", 1'b1, 0, 6'h08, 'hbad,   'hbad,  'hbad,  'habcdef, 'hbad, 1'b0, 1'b0, 0, 0,    0, 0, 1'b0));
        tbl.push_back(mk("mono_len",1'b1, 2, 6'h02, 0,       'h200,  0,      0,        0,    1'b0, 1'b0, 0, 0,     2, 1, 1'b0));
        tbl.push_back(mk("wr3_tag", 1'b1, 3, 6'h23, 'h5000,  'h10,   0,      0,        0,    1'b1, 1'b0, 0, 0,     3, 0, 1'b0));
        tbl.push_back(mk("shrink3", 1'b1, 3, 6'h03, 'h5008,  'h8,    0,      0,        0,    1'b0, 1'b0, 0, 0,     3, 3, 1'b0));
        tbl.push_back(mk("mono_bas",1'b1, 3, 6'h01, 'h4ff0,  0,      0,      0,        0,    1'b0, 1'b0, 0, 0,     3, 2, 1'b0));
        tbl.push_back(mk("rst_mid", 1'b0, 2, 6'h01, 'hdead,  0,      0,      0,        0,    1'b0, 1'b0, 0, 0,     2, 0, 1'b0));
        tbl.push_back(mk("after_rst",1'b1,0, 6'h00, 0,       0,      0,      0,        0,    1'b0, 1'b0, 0, 0,     2, 3, 1'b0));

        foreach (tbl[i]) run_vec(tbl[i], 1'b1);

        // Back-to-back collisions: the conflict pulse must re-assert each cycle, then drop.
        run_vec(mk("coll_b2b0", 1'b1, 0, 6'h04, 0, 0, 'hA0, 0, 0, 1'b0, 1'b1, 0, 'hB0, 0, 1, 1'b1), 1'b1);
        run_vec(mk("coll_b2b1", 1'b1, 1, 6'h04, 0, 0, 'hA1, 0, 0, 1'b0, 1'b1, 1, 'hB1, 1, 0, 1'b1), 1'b1);
        run_vec(mk("coll_end",  1'b1, 1, 6'h00, 0, 0, 0,    0, 0, 1'b0, 1'b1, 1, 'hB2, 1, 0, 1'b0), 1'b1);

        for (int k = 0; k < 60; k++) begin
            v = mk("rand", ($urandom_range(0, 19) != 0), $urandom_range(0, NUM_CR-1),
                   6'($urandom), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                   {$urandom(), $urandom()}, int'($urandom()), int'($urandom()), 1'($urandom()),
                   1'($urandom()), $urandom_range(0, NUM_CR-1), {$urandom(), $urandom()},
                   $urandom_range(0, NUM_CR-1), $urandom_range(0, NUM_CR-1), 1'b0);
            run_vec(v, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
